// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - handshake and SPI pin bundle for spi_master
//   master modport : the spi_master side
//     spi_start, spi_out, miso          in
//     spi_busy, spi_in, sclk, mosi, cs_n out
//   slave modport  : the upstream controller / SPI device side (directions mirrored)
interface spi_master_if;
    logic       spi_start;
    logic [7:0] spi_out;
    logic       spi_busy;
    logic [7:0] spi_in;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  spi_start, spi_out, miso,
        output spi_busy, spi_in, sclk, mosi, cs_n
    );

    modport slave (
        output spi_start, spi_out, miso,
        input  spi_busy, spi_in, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide SPI master, mode 0, MSB first
//   Optional feature macro: SPI_CS_HOLD_EN (keeps cs_n low for CS_HOLD_CYCLES
//   after a byte so a following byte can skip the setup phase).
//   Parameters:
//     CLK_DIV         system clock cycles per SCLK half-period (>= 1)
//     CS_HOLD_CYCLES  cs_n hold window after a byte (only with SPI_CS_HOLD_EN)
//   Ports:
//     clk    in  system clock, all logic on posedge
//     reset  in  synchronous, active-low
//     bus    spi_master_if.master:
//       spi_start in  request to send spi_out (sampled only while spi_busy=0)
//       spi_out   in  byte to send, latched on accept
//       spi_busy  out high from cycle after accept until transfer done
//       spi_in    out last received byte, updated when spi_busy falls
//       sclk      out SPI clock, idle low
//       mosi      out serial data out
//       miso      in  serial data in
//       cs_n      out chip select, active low
module spi_master #(
    parameter int CLK_DIV = 2
`ifdef SPI_CS_HOLD_EN
    ,
    parameter int CS_HOLD_CYCLES = 8
`endif
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.master bus
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef SPI_CS_HOLD_EN
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam int HOLD_W = $clog2(CS_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD_CYCLES - 1);
`endif

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;     // half-period index 0..15
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       spi_in_q, spi_in_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
`ifdef SPI_CS_HOLD_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    logic half_end;
    assign half_end = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        spi_in_d = spi_in_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        busy_d   = busy_q;
`ifdef SPI_CS_HOLD_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.spi_start) begin
                    tx_d    = bus.spi_out;
                    mosi_d  = bus.spi_out[7];
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // cs_n-to-first-edge setup: one half-period with sclk low
                if (half_end) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!half_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Even half-periods end on a rising edge, odd ones on a falling edge.
                    if (!bit_q[0]) begin
                        rx_d = {rx_q[6:0], bus.miso};
                    end else begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (bit_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                spi_in_d = rx_q;
                busy_d   = 1'b0;
                mosi_d   = 1'b0;
`ifdef SPI_CS_HOLD_EN
                hold_d   = '0;
                state_d  = ST_HOLD;
`else
                cs_n_d   = 1'b1;
                state_d  = ST_IDLE;
`endif
            end
`ifdef SPI_CS_HOLD_EN
            ST_HOLD: begin
                // A new request wins over the timeout, even on the last hold cycle.
                // cs_n is already low, so the setup phase is skipped.
                if (bus.spi_start) begin
                    tx_d    = bus.spi_out;
                    mosi_d  = bus.spi_out[7];
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end else if (hold_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            spi_in_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
`ifdef SPI_CS_HOLD_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            spi_in_q <= spi_in_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
`ifdef SPI_CS_HOLD_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign bus.spi_busy = busy_q;
    assign bus.spi_in   = spi_in_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;

endmodule
